// File: rtl/acq_sched_pkg.sv
// Shared types and constants for the acquisition mode scheduler.
package acq_sched_pkg;

  localparam int unsigned MODE_W = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [MODE_W-1:0] MODE_MICROROC = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_SCURVE   = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_ADC      = MODE_W'(2);
  localparam logic [MODE_W-1:0] MODE_COUNT    = MODE_W'(3);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STOP_WAIT = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_SWITCH    = 3'd4,
    ST_SETTLE    = 3'd5
  } state_t;

  // True for a mode code that names an existing acquisition resource.
  function automatic logic mode_valid(input logic [MODE_W-1:0] mode);
    return mode < MODE_COUNT;
  endfunction

endpackage

// File: rtl/acq_sched_timer.sv
// Saturating cycle counter shared by the timed scheduler states.
// 'clear' marks the first cycle of a timed state: the count reads as zero
// in that cycle so the terminal compare is correct immediately on entry.
module acq_sched_timer
  import acq_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal_c
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_c;

  assign count_c    = clear ? '0 : count;
  assign terminal_c = (count_c == limit);

  // Count up while enabled, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= (count_c == '1) ? count_c : count_c + CNT_W'(1);
    end
  end

endmodule

// File: rtl/acquisition_mode_scheduler.sv
// Serialises Microroc / S-curve / ADC acquisition: one mode at a time, and
// mode changes only after the active mode is idle and the FIFO has drained.
module acquisition_mode_scheduler
  import acq_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40000,
  parameter int unsigned SETTLE_CYCLES  = 8
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] ModeRequest,
  input  logic              ModeRequestValid,
  input  logic              StartRequest,
  input  logic              StopRequest,
  input  logic              MicrorocAcqIdle,
  input  logic              SCurveTestDone,
  input  logic              AdcIdle,
  input  logic              ExternalFifoEmpty,
  output logic [MODE_W-1:0] ModeSelect,
  output logic              CommandMicrorocAcquisitionStartStop,
  output logic              CommandSCurveTestStartStop,
  output logic              CommandAdcStartStop,
  output logic              Running,
  output logic              Busy,
  output logic              Timeout,
  output logic              RequestError
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state;
  logic [MODE_W-1:0] pending;
  logic              timer_clear;
  logic              timer_enable_c;
  logic              timer_terminal_c;
  logic [CNT_W-1:0]  timer_limit_c;
  logic              req_valid_c;
  logic              req_invalid_c;
  logic              xfer_req_c;
  logic [MODE_W-1:0] pending_eff_c;
  logic              mode_idle_c;

  assign req_valid_c    = ModeRequestValid && mode_valid(ModeRequest);
  assign req_invalid_c  = ModeRequestValid && !mode_valid(ModeRequest);
  assign xfer_req_c     = StartRequest || StopRequest;
  assign pending_eff_c  = req_valid_c ? ModeRequest : pending;
  assign timer_enable_c = (state == ST_STOP_WAIT) || (state == ST_DRAIN) ||
                          (state == ST_SETTLE);
  assign timer_limit_c  = (state == ST_SETTLE) ? SETTLE_LAST : TIMEOUT_LAST;

  // Idle indication of the mode currently selected.
  always_comb begin
    mode_idle_c = 1'b1;
    case (ModeSelect)
      MODE_MICROROC: mode_idle_c = MicrorocAcqIdle;
      MODE_SCURVE:   mode_idle_c = SCurveTestDone;
      MODE_ADC:      mode_idle_c = AdcIdle;
      default:       mode_idle_c = 1'b1;
    endcase
  end

  acq_sched_timer u_timer (
    .clk        (Clk),
    .reset      (reset),
    .clear      (timer_clear),
    .enable     (timer_enable_c),
    .limit      (timer_limit_c),
    .terminal_c (timer_terminal_c)
  );

  // Scheduler FSM; outputs are updated on the same edge as the state.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state                               <= ST_IDLE;
      ModeSelect                          <= MODE_MICROROC;
      pending                             <= MODE_MICROROC;
      CommandMicrorocAcquisitionStartStop <= 1'b0;
      CommandSCurveTestStartStop          <= 1'b0;
      CommandAdcStartStop                 <= 1'b0;
      Running                             <= 1'b0;
      Busy                                <= 1'b0;
      Timeout                             <= 1'b0;
      RequestError                        <= 1'b0;
      timer_clear                         <= 1'b0;
    end else begin
      RequestError <= req_invalid_c;
      timer_clear  <= 1'b0;
      if (req_valid_c) begin
        pending <= ModeRequest;
        Timeout <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (req_valid_c) begin
            if (StartRequest) RequestError <= 1'b1;
            if (ModeRequest != ModeSelect) begin
              state <= ST_SWITCH;
              Busy  <= 1'b1;
            end
          end else if (pending != ModeSelect) begin
            // Request deferred from SWITCH/SETTLE is applied now.
            if (StartRequest) RequestError <= 1'b1;
            state <= ST_SWITCH;
            Busy  <= 1'b1;
          end else if (StartRequest) begin
            state                               <= ST_RUN;
            Running                             <= 1'b1;
            Timeout                             <= 1'b0;
            CommandMicrorocAcquisitionStartStop <= (ModeSelect == MODE_MICROROC);
            CommandSCurveTestStartStop          <= (ModeSelect == MODE_SCURVE);
            CommandAdcStartStop                 <= (ModeSelect == MODE_ADC);
          end
        end

        ST_RUN: begin
          if (StopRequest || req_valid_c ||
              ((ModeSelect == MODE_SCURVE) && SCurveTestDone)) begin
            state                               <= ST_STOP_WAIT;
            Running                             <= 1'b0;
            Busy                                <= 1'b1;
            CommandMicrorocAcquisitionStartStop <= 1'b0;
            CommandSCurveTestStartStop          <= 1'b0;
            CommandAdcStartStop                 <= 1'b0;
            timer_clear                         <= 1'b1;
          end
        end

        ST_STOP_WAIT: begin
          if (xfer_req_c) RequestError <= 1'b1;
          if (mode_idle_c) begin
            state       <= ST_DRAIN;
            timer_clear <= 1'b1;
          end else if (timer_terminal_c) begin
            Timeout     <= 1'b1;
            state       <= ST_DRAIN;
            timer_clear <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (xfer_req_c) RequestError <= 1'b1;
          if (ExternalFifoEmpty || timer_terminal_c) begin
            if (!ExternalFifoEmpty) Timeout <= 1'b1;
            if (pending_eff_c != ModeSelect) begin
              state <= ST_SWITCH;
            end else begin
              state <= ST_IDLE;
              Busy  <= 1'b0;
            end
          end
        end

        ST_SWITCH: begin
          if (xfer_req_c) RequestError <= 1'b1;
          ModeSelect  <= pending;
          state       <= ST_SETTLE;
          timer_clear <= 1'b1;
        end

        ST_SETTLE: begin
          if (xfer_req_c) RequestError <= 1'b1;
          if (timer_terminal_c) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
